m_mux_rr: RTL
=============

# m_mux_rr

Parametrised N-channel, W-bit registered multiplexer with round-robin arbitration and valid/ready handshaking. It is the sequential successor to the 16-bit 2:1 mux. Several producers share one downstream consumer, and the block chooses the source itself instead of taking an external select. It sits between producers such as ALU/register-file read ports and a shared bus or the memory write path.

## Interface
Parameters:
- WIDTH, 16, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- CW, derived as $clog2(CHANNELS), channel index width (localparam, not overridable)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_data  in  CHANNELS*WIDTH  packed inputs; channel k is bits [k*WIDTH +: WIDTH]
- i_valid  in  CHANNELS  per-channel data valid
- o_ready  out  CHANNELS  per-channel accept, combinational, one-hot or zero
- o_data  out  WIDTH  registered output data
- o_valid  out  1  registered output valid
- o_chan  out  CW  index of the channel that produced o_data
- i_ready  in  1  downstream accept

## Operation
- Transfer rules:
  - Input transfer on channel k: i_valid[k] & o_ready[k] at a rising edge.
  - Output transfer: o_valid & i_ready at a rising edge.
- State held in registers:
  - Output register: o_data, o_valid, o_chan.
  - Priority pointer ptr (CW bits).
- can_load = !o_valid | i_ready. This gives single-register pipelining with a full-throughput pass-through when downstream is ready.
- Grant g: the first k with i_valid[k] set, searching from ptr upward with wrap (ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1). No grant if i_valid is all zero.
- o_ready[g] = can_load & grant_exists & !i_rst. All other o_ready bits are 0. o_ready depends only on i_valid, i_ready and registered state.
- On an input transfer:
  - o_data ← channel g data, o_chan ← g, o_valid ← 1.
  - ptr ← (g == CHANNELS-1) ? 0 : g+1.
- On an output transfer with no input transfer: o_valid ← 0. o_data and o_chan hold their last values.
- On neither transfer: all registers hold. A stalled output (o_valid & !i_ready) keeps o_data and o_chan stable.
- ptr changes only on an input transfer. Idle cycles do not rotate priority.
- Producers may drop i_valid without a transfer. The block does not require valid to be held.

## Timing
- Reset values: o_valid=0, o_data=0, o_chan=0, ptr=0. o_ready is all zero while i_rst=1.
- Reset mid-operation: any held output word is discarded and no input is accepted in the reset cycle. The first grant after reset starts its search at channel 0.
- Latency: 1 cycle from input transfer to o_valid.
- Throughput: 1 word/cycle when i_ready is held high.
- Simultaneous output and input transfer in one cycle: the new word loads and o_valid stays 1.
- Fairness: when all CHANNELS requesters stay continuously valid, each is granted exactly once in every CHANNELS consecutive transfers.
- Wrap-around: a grant to CHANNELS-1 sets ptr to 0. For non-power-of-two CHANNELS, ptr never exceeds CHANNELS-1.

## Configuration
- M_MUX_RR_FIXED_PRIO_EN, when defined:
  - Arbitration is fixed priority and the lowest valid index always wins.
  - ptr is not implemented; o_ready, latency and handshake are otherwise identical.
- When undefined: round-robin as specified above (default build).

## Test plan
- Reset: hold i_rst=1 for 2 cycles with all i_valid=1 -> o_ready=0000, o_valid=0, o_data=0x0000, o_chan=0 throughout. The first grant after release goes to channel 0.
- Single channel: i_valid=0100 with ch2=0xBEEF and i_ready=1 -> o_ready=0100 in that cycle; next cycle o_valid=1, o_data=0xBEEF, o_chan=2.
- Round robin: i_valid=1111 continuously with ch k = 0x1000+k and i_ready=1 -> o_chan sequence 0,1,2,3,0,1 with one word per cycle.
- Backpressure: o_valid=1 holding 0xA5A5 with i_ready=0 for 3 cycles and i_valid=0011 -> o_ready=0000, and o_data stays 0xA5A5/o_chan stays stable. When i_ready rises, the next word loads in the same edge and o_valid stays 1.
- Skip and wrap: ptr=3 after a grant to ch2 with i_valid=0101 -> ch0 is granted, then ch2.
- With M_MUX_RR_FIXED_PRIO_EN: i_valid=1111 held -> o_chan=0 on every transfer.

Source files
------------

// File: rtl/m_mux_rr.sv
// N-channel registered multiplexer with round-robin arbitration and valid/ready handshake.
// Define M_MUX_RR_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module m_mux_rr #(
  parameter  int unsigned WIDTH    = 16,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned CW       = $clog2(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       o_ready,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_valid,
  output logic [CW-1:0]             o_chan,
  input  logic                      i_ready
);

  logic              can_load;
  logic              take;
  logic              grant_found;
  logic [CW-1:0]     grant;
  logic [CW-1:0]     start;
  logic [WIDTH-1:0]  sel_data;

`ifdef M_MUX_RR_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [CW-1:0] ptr;
  assign start = ptr;
`endif

  assign can_load = !o_valid || i_ready;
  assign take     = grant_found && can_load && !i_rst;

  // Wrapped search from start; the index is folded back below CHANNELS so
  // non-power-of-two channel counts never select a nonexistent requester.
  always_comb begin : arbitrate
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant       = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = 32'(start) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_found && i_valid[CW'(idx)]) begin
        grant_found = 1'b1;
        grant       = CW'(idx);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (grant == CW'(k)) sel_data = i_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    o_ready = '0;
    if (take) o_ready[grant] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_chan  <= '0;
    end else if (take) begin
      o_valid <= 1'b1;
      o_data  <= sel_data;
      o_chan  <= grant;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifndef M_MUX_RR_FIXED_PRIO_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (grant == CW'(CHANNELS-1)) ? '0 : grant + CW'(1);
    end
  end
`endif

endmodule
